// File: rtl/morphle_pkg.sv
// Shared lane encoding and state definitions for the Morphle red-cell edge port.
package morphle_pkg;

  localparam logic [1:0] VEMPTY = 2'b00;
  localparam logic [1:0] V0     = 2'b01;
  localparam logic [1:0] V1     = 2'b10;
  localparam logic [1:0] VILL   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_RTZ   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  function automatic logic [1:0] lane_enc(input logic b);
    return b ? V1 : V0;
  endfunction

endpackage

// File: rtl/morphle_sync2.sv
// Two-flop synchronizer bank for the asynchronous back rails.
module morphle_sync2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/morphle_redport.sv
// Clocked red-cell edge port: drives a word into the ycell top row as dual-rail
// values, waits for a stable result on the back rails, returns to empty, delivers it.
//
//  state | meaning
//  IDLE  | ready for a word, all lanes empty
//  DRIVE | word on uin, waiting for every back lane to settle non-empty
//  RTZ   | lanes returned to empty, waiting for back rails to clear
//  DONE  | result presented, waiting for consumer
//  ERR   | timeout or illegal lane; array held in reset for 4 cycles
module morphle_redport
  import morphle_pkg::*;
#(
  parameter int N      = 8,
  parameter int STABLE = 2,
  parameter int TMO    = 255
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [2*N-1:0] a_out,
  output logic [N-1:0]   a_uempty,
  input  logic [2*N-1:0] a_back,
  output logic           a_reset,
  output logic [N-1:0]   res_data,
  output logic           res_valid,
  input  logic           res_ready,
  output logic           err
);

  localparam int TW = $clog2(TMO + 1);
  localparam int SW = $clog2(STABLE + 1);

  state_e         state_q, state_d;
  logic [2*N-1:0] sb, sb_prev_q;
  logic [SW-1:0]  stab_q, stab_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [1:0]     ecnt_q, ecnt_d;
  logic [2*N-1:0] a_out_q, a_out_d;
  logic [N-1:0]   res_data_q, res_data_d;
  logic           in_ready_q, res_valid_q, a_reset_q, err_q;
  logic           all_full, all_empty, any_ill, stable_ok;

  morphle_sync2 #(.W(2*N)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (a_back),
    .q_o     (sb)
  );

  // Count includes the current cycle, so a one-cycle glitch can never be accepted.
  always_comb begin
    stab_d = stab_q;
    if (sb != sb_prev_q) begin
      stab_d = '0;
    end else if (stab_q < SW'(STABLE)) begin
      stab_d = stab_q + 1'b1;
    end
    stable_ok = (stab_d == SW'(STABLE));
  end

  always_comb begin
    all_full  = 1'b1;
    all_empty = 1'b1;
    any_ill   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sb[2*i +: 2] == VEMPTY) all_full = 1'b0;
      if (sb[2*i +: 2] != VEMPTY) all_empty = 1'b0;
      if (sb[2*i +: 2] == VILL) any_ill = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_out_d    = a_out_q;
    res_data_d = res_data_q;
    tmo_d      = tmo_q;
    ecnt_d     = ecnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          for (int i = 0; i < N; i++) a_out_d[2*i +: 2] = lane_enc(in_data[i]);
          tmo_d   = TW'(TMO - 1);
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (any_ill) begin
          state_d = ST_ERR;
        end else if (all_full && stable_ok) begin
          for (int i = 0; i < N; i++) res_data_d[i] = sb[2*i+1];
          a_out_d = '0;
          tmo_d   = TW'(TMO - 1);
          state_d = ST_RTZ;
        end else if (tmo_q == '0) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      ST_RTZ: begin
        if (any_ill) begin
          state_d = ST_ERR;
        end else if (all_empty && stable_ok) begin
          state_d = ST_DONE;
        end else if (tmo_q == '0) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (ecnt_q == 2'd0) state_d = ST_IDLE;
        else ecnt_d = ecnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_ERR && state_q != ST_ERR) begin
      a_out_d = '0;
      ecnt_d  = 2'd3;
    end
  end

  // Outputs are registered from the next state so they change only at clock edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sb_prev_q   <= '0;
      stab_q      <= '0;
      tmo_q       <= '0;
      ecnt_q      <= '0;
      a_out_q     <= '0;
      res_data_q  <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      a_reset_q   <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sb_prev_q   <= sb;
      stab_q      <= stab_d;
      tmo_q       <= tmo_d;
      ecnt_q      <= ecnt_d;
      a_out_q     <= a_out_d;
      res_data_q  <= res_data_d;
      in_ready_q  <= (state_d == ST_IDLE);
      res_valid_q <= (state_d == ST_DONE);
      a_reset_q   <= (state_d == ST_ERR);
      err_q       <= err_q | (state_d == ST_ERR);
    end
  end

  assign in_ready  = in_ready_q;
  assign a_out     = a_out_q;
  assign a_uempty  = '0;
  assign a_reset   = a_reset_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_morphle_redport.sv
// Directed bench for morphle_redport: echo model of the array, glitch, timeout, illegal lane, reset.
module tb_morphle_redport;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_out;
  logic [7:0]  a_uempty;
  logic [15:0] a_back;
  logic        a_reset;
  logic [7:0]  res_data;
  logic        res_valid;
  logic        res_ready;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;
  logic        echo_en;
  logic [15:0] d1, d2, d3;

  always #5 clk = ~clk;

  morphle_redport #(.N(8), .STABLE(2), .TMO(255)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_out     (a_out),
    .a_uempty  (a_uempty),
    .a_back    (a_back),
    .a_reset   (a_reset),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1ns after the edge; the echo model returns a_out a few cycles later.
  task automatic tick();
    @(posedge clk);
    #1;
    d3 = d2;
    d2 = d1;
    d1 = a_out;
    if (echo_en) a_back = d3;
  endtask

  task automatic clear_echo();
    d1 = '0; d2 = '0; d3 = '0;
    a_back = '0;
  endtask

  initial begin
    int n;
    int m;
    logic rv_seen;
    reset_n = 1'b0; in_data = '0; in_valid = 1'b0; res_ready = 1'b0;
    echo_en = 1'b1;
    clear_echo();

    #12;
    chk("rst_a_out", a_out, 16'h0000);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_a_reset", a_reset, 1'b1);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 8'h00);
    chk("rst_err", err, 1'b0);
    chk("a_uempty", a_uempty, 8'h00);
    @(negedge clk) reset_n = 1'b1;
    tick();
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_a_reset", a_reset, 1'b0);

    // 1: A5 -> lanes {7..0} = 10 01 10 01 01 10 01 10 = 16'h9966
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_a_out", a_out, 16'h9966);
    chk("t1_in_ready", in_ready, 1'b0);
    n = 0;
    while (!res_valid && n < 100) begin tick(); n++; end
    chk("t1_res_valid", res_valid, 1'b1);
    chk("t1_res_data", res_data, 8'hA5);
    chk("t1_a_out_rtz", a_out, 16'h0000);

    // 6: hold result for 10 cycles with a second word pending
    in_data = 8'h0F; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_res_valid_hold", res_valid, 1'b1);
      chk("t6_res_data_hold", res_data, 8'hA5);
      chk("t6_in_ready_low", in_ready, 1'b0);
      chk("t6_a_out_idle", a_out, 16'h0000);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t6_res_valid_drop", res_valid, 1'b0);
    chk("t6_in_ready_back", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("t6_second_a_out", a_out, 16'h55AA);
    n = 0;
    while (!res_valid && n < 100) begin tick(); n++; end
    chk("t6_second_valid", res_valid, 1'b1);
    chk("t6_second_data", res_data, 8'h0F);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // 2: one-cycle glitch on lane 0 (01 -> 10 -> 01); 3C -> 16'h5AA5
    echo_en = 1'b0;
    clear_echo();
    in_data = 8'h3C; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t2_a_out", a_out, 16'h5AA5);
    a_back = 16'h5AA5;
    tick();
    a_back = 16'h5AA6;
    tick();
    a_back = 16'h5AA5;
    n = 0;
    while (a_out != 16'h0000 && n < 50) begin tick(); n++; end
    chk("t2_drive_exit", a_out, 16'h0000);
    chk("t2_res_data", res_data, 8'h3C);
    chk("t2_no_valid_yet", res_valid, 1'b0);
    a_back = 16'h0000;
    n = 0;
    while (!res_valid && n < 50) begin tick(); n++; end
    chk("t2_res_valid", res_valid, 1'b1);
    chk("t2_res_data_done", res_data, 8'h3C);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // 5: reset pulse while in RTZ
    echo_en = 1'b1;
    clear_echo();
    in_data = 8'h5A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (a_out != 16'h0000 && n < 50) begin tick(); n++; end
    chk("t5_in_rtz", in_ready, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_a_out", a_out, 16'h0000);
    chk("t5_async_res_valid", res_valid, 1'b0);
    chk("t5_async_err", err, 1'b0);
    chk("t5_async_a_reset", a_reset, 1'b1);
    chk("t5_async_res_data", res_data, 8'h00);
    clear_echo();
    @(negedge clk) reset_n = 1'b1;
    tick();
    chk("t5_idle_in_ready", in_ready, 1'b1);
    chk("t5_a_reset_drop", a_reset, 1'b0);

    // 3: back rails stay empty -> timeout after TMO cycles in DRIVE
    echo_en = 1'b0;
    clear_echo();
    in_data = 8'h81; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!err && n < 400) begin tick(); n++; end
    chk("t3_tmo_cycles", n, 255);
    chk("t3_err", err, 1'b1);
    chk("t3_a_out", a_out, 16'h0000);
    m = 0;
    while (a_reset && m < 10) begin m++; tick(); end
    chk("t3_a_reset_len", m, 4);
    chk("t3_in_ready", in_ready, 1'b1);
    chk("t3_err_sticky", err, 1'b1);

    reset_n = 1'b0;
    #3;
    chk("t3_err_cleared", err, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    tick();

    // 4: lane 3 illegal 11 in DRIVE
    in_data = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t4_a_out", a_out, 16'hAAAA);
    a_back = 16'hAAEA;
    rv_seen = 1'b0;
    n = 0;
    while (!err && n < 20) begin tick(); n++; rv_seen |= res_valid; end
    chk("t4_err_latency", n, 3);
    chk("t4_a_out_err", a_out, 16'h0000);
    chk("t4_a_reset", a_reset, 1'b1);
    a_back = 16'h0000;
    for (int i = 0; i < 8; i++) begin tick(); rv_seen |= res_valid; end
    chk("t4_no_res_valid", rv_seen, 1'b0);
    chk("t4_in_ready", in_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
